// File: rtl/pipe_stage_buf.sv
// Elastic pipeline buffer: DEPTH-entry circular FIFO between two stages,
// with stall (hold), synchronous flush and asynchronous reset.
module pipe_stage_buf #(
  parameter int                 DATA_W  = 64,
  parameter int                 DEPTH   = 2,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic                      clk_100MHz,
  input  logic                      arst_n,
  input  logic                      flush_i,
  input  logic                      hold_ena_i,
  input  logic                      in_valid_i,
  input  logic [DATA_W-1:0]         in_data_i,
  output logic                      in_ready_o,
  output logic                      out_valid_o,
  output logic [DATA_W-1:0]         out_data_o,
  input  logic                      out_ready_i,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == L_FULL);
  assign w_empty = (r_count == '0);

  // Ready is gated by reset so upstream sees back-pressure while held.
  assign in_ready_o  = arst_n && !w_full && !hold_ena_i && !flush_i;
  assign out_valid_o = !w_empty && !hold_ena_i;
  assign out_data_o  = w_empty ? RST_VAL : r_mem[r_rptr];
  assign count_o     = r_count;

  assign w_push = in_valid_i && in_ready_o;
  assign w_pop  = out_valid_o && out_ready_i && !flush_i;

  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; empty state masks it on the output.
  always_ff @(posedge clk_100MHz) begin
    if (w_push) r_mem[r_wptr] <= in_data_i;
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL provide parameter DATA_W, default 64, width of one pipeline payload word (packed inst/ctrl/data bundle).
REQ-002 SHALL provide parameter DEPTH, default 2, number of buffered entries; legal values are powers of two from 2 to 16.
REQ-003 SHALL provide parameter RST_VAL, default all-zero DATA_W value, driven on out_data_o whenever the buffer is empty.
REQ-004 clk_100MHz  input  1  system clock; all state updates on the rising edge.
REQ-005 arst_n  input  1  asynchronous, active-low reset.
REQ-006 flush_i  input  1  synchronous discard of all buffered entries.
REQ-007 hold_ena_i  input  1  system stall; freezes all state.
REQ-008 in_valid_i  input  1  upstream payload valid.
REQ-009 in_data_i  input  DATA_W  upstream payload.
REQ-010 in_ready_o  output  1  buffer can accept a payload this cycle.
REQ-011 out_valid_o  output  1  head entry is presented downstream.
REQ-012 out_data_o  output  DATA_W  head entry payload.
REQ-013 out_ready_i  input  1  downstream accepts the head entry.
REQ-014 count_o  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

Function
REQ-015 Storage SHALL be a DEPTH-entry circular buffer with write pointer, read pointer and occupancy count, all registered.
REQ-016 Push SHALL occur when in_valid_i && in_ready_o && !flush_i.
REQ-017 Pop SHALL occur when out_valid_o && out_ready_i && !flush_i.
REQ-018 in_ready_o SHALL equal (count != DEPTH) && !hold_ena_i && !flush_i, with no combinational path from out_ready_i.
REQ-019 out_valid_o SHALL equal (count != 0) && !hold_ena_i.
REQ-020 out_data_o SHALL equal the entry at the read pointer when count != 0, and RST_VAL otherwise.
REQ-021 Latency: a payload pushed at edge N SHALL be visible on out_data_o with out_valid_o high after edge N; there is no same-cycle input-to-output bypass.
REQ-022 Ordering SHALL be strict FIFO; payloads are never reordered, duplicated or dropped except by flush_i.
REQ-023 Pointers SHALL wrap modulo DEPTH: DEPTH-1 increments to 0.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-025 Full: in_ready_o is low, so a pop at full frees a slot usable only from the next cycle (no pass-through at full).
REQ-026 Empty: out_valid_o is low, so a push into an empty buffer cannot be popped in the same cycle.
REQ-027 hold_ena_i high SHALL block push and pop and keep pointers, count and storage unchanged.
REQ-028 flush_i SHALL take priority over hold_ena_i and over any push/pop.
REQ-029 On the edge where flush_i is high, count and both pointers SHALL be cleared and any concurrent in_valid_i payload discarded.
REQ-030 Storage contents need not be cleared by flush_i; they are unobservable because out_data_o shows RST_VAL while empty.
REQ-031 count_o SHALL be the registered occupancy count, never exceeding DEPTH.

Reset
REQ-032 While arst_n is low, asynchronously: count=0, pointers=0, out_valid_o=0, out_data_o=RST_VAL, in_ready_o=0 (reset held).
REQ-033 After arst_n deasserts, in_ready_o SHALL be 1 in the first cycle unless hold_ena_i or flush_i is high.
REQ-034 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-035 Storage array contents need not be reset.

Verification
REQ-036 DEPTH=2, out_ready_i=0: push 0xA1, 0xB2 -> count_o=2, in_ready_o=0, out_data_o=0xA1; raise out_ready_i -> 0xA1 then 0xB2 emitted, count_o returns to 0.
REQ-037 DEPTH=4, in_valid_i and out_ready_i held high, payloads 1..20 -> outputs 1..20 in order, pointers wrap 5 times, count_o settles at 1.
REQ-038 Count=2 holding 0x11, 0x22, then hold_ena_i high 3 cycles with in_valid_i=1 and out_ready_i=1 -> out_valid_o=0, in_ready_o=0, count_o=2 throughout; release -> 0x11 emitted first.
REQ-039 Count=3 with flush_i=1 concurrent with in_valid_i=1 (0x55) and hold_ena_i=1 -> next cycle count_o=0, out_valid_o=0, out_data_o=RST_VAL, 0x55 never emitted.
REQ-040 Count=2 mid-stream, arst_n pulsed low between clock edges -> out_valid_o=0 and count_o=0 before the next edge; the first payload after release is emitted unchanged.
REQ-041 Full DEPTH=2 with out_ready_i=1 and in_valid_i=1 -> in the pop cycle in_ready_o=0; in the following cycle the push is accepted and count_o stays at or below 2.
